// File: rtl/game_pkg.sv
// Shared FSM encoding, building/click limits and arithmetic helpers for game_scheduler.
package game_pkg;

  localparam int NUM_BUILDINGS = 8;
  localparam int MAX_CLICK_LVL = 7;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUY_CHK = 2'd1;
  localparam logic [1:0] S_UPG_CHK = 2'd2;
  localparam logic [1:0] S_PROD    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_BUY_CHK = S_BUY_CHK,
    ST_UPG_CHK = S_UPG_CHK,
    ST_PROD    = S_PROD
  } state_e;

  // Helpers work at 64 bits; callers keep BAL_W+CNT_W+7 within that.
  function automatic logic [63:0] price(input logic [2:0] idx, input int unsigned base);
    return 64'(base) << (2 * idx);
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] lim;
    logic [63:0] sum;
    lim = (64'd1 << w) - 64'd1;
    sum = a + b;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/game_tick_divider.sv
// Free-running 0..TICK_DIV-1 counter; o_tick is high for the one cycle before each wrap.
module game_tick_divider #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic resetn,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_scheduler.sv
// Cookie game sequencer: click, buy, upgrade and production share one saturating add/sub unit.
// Define GAME_TOTAL_EARNED_EN to add the total_earned output.
module game_scheduler
  import game_pkg::*;
#(
  parameter int BAL_W      = 32,
  parameter int CNT_W      = 8,
  parameter int TICK_DIV   = 50000000,
  parameter int PRICE_BASE = 10,
  parameter int UPG_BASE   = 50
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             click,
  input  logic             buy,
  input  logic             one,
  input  logic             two,
  input  logic             three,
  input  logic             four,
  input  logic             five,
  input  logic             six,
  input  logic             seven,
  input  logic             eight,
  input  logic             selection,
  input  logic             upgradeClick,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       sel_idx,
  output logic [CNT_W-1:0] sel_count,
  output logic [2:0]       click_lvl,
  output logic             buy_ok,
  output logic             buy_fail,
  output logic             busy
`ifdef GAME_TOTAL_EARNED_EN
  ,
  output logic [BAL_W-1:0] total_earned
`endif
);

  localparam int WW = BAL_W + CNT_W + 7;

  state_e           r_state;
  logic [BAL_W-1:0] r_balance;
  logic [CNT_W-1:0] r_count [NUM_BUILDINGS];
  logic [2:0]       r_sel_idx;
  logic [2:0]       r_buy_idx;
  logic [2:0]       r_idx;
  logic [2:0]       r_click_lvl;
  logic             r_click_pend;
  logic             r_buy_pend;
  logic             r_upg_pend;
  logic             r_tick_pend;
  logic             r_buy_ok;
  logic             r_buy_fail;

  logic             w_tick;
  logic [7:0]       w_sel_vec;
  logic [2:0]       w_sel_new;
  logic             w_idle;
  logic             w_clr_tick;
  logic             w_clr_buy;
  logic             w_clr_upg;
  logic             w_clr_click;
  logic [WW-1:0]    w_bal_wide;
  logic [WW-1:0]    w_buy_price;
  logic [WW-1:0]    w_upg_cost;
  logic [WW-1:0]    w_operand;
  logic             w_buy_pass;
  logic             w_upg_pass;
  logic             w_do_op;
  logic             w_op_sub;
  logic [BAL_W-1:0] w_alu_res;

  game_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .o_tick (w_tick)
  );

  assign w_sel_vec = {eight, seven, six, five, four, three, two, one};

  always_comb begin
    w_sel_new = 3'd0;
    for (int i = NUM_BUILDINGS - 1; i >= 0; i--) begin
      if (w_sel_vec[i]) w_sel_new = 3'(i);
    end
  end

  // Each pending flag is consumed only when it is the highest-priority one in IDLE.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_clr_tick  = w_idle & r_tick_pend;
  assign w_clr_buy   = w_idle & ~r_tick_pend & r_buy_pend;
  assign w_clr_upg   = w_idle & ~r_tick_pend & ~r_buy_pend & r_upg_pend;
  assign w_clr_click = w_idle & ~r_tick_pend & ~r_buy_pend & ~r_upg_pend & r_click_pend;

  assign w_bal_wide  = WW'(r_balance);
  assign w_buy_price = WW'(price(r_buy_idx, PRICE_BASE));
  assign w_upg_cost  = WW'(UPG_BASE) << r_click_lvl;
  assign w_buy_pass  = (w_bal_wide >= w_buy_price) && (r_count[r_buy_idx] != {CNT_W{1'b1}});
  assign w_upg_pass  = (r_click_lvl < 3'(MAX_CLICK_LVL)) && (w_bal_wide >= w_upg_cost);

  always_comb begin
    w_do_op   = 1'b0;
    w_op_sub  = 1'b0;
    w_operand = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_click) begin
          w_do_op   = 1'b1;
          w_operand = WW'(1) << r_click_lvl;
        end
      end
      ST_BUY_CHK: begin
        if (w_buy_pass) begin
          w_do_op   = 1'b1;
          w_op_sub  = 1'b1;
          w_operand = w_buy_price;
        end
      end
      ST_UPG_CHK: begin
        if (w_upg_pass) begin
          w_do_op   = 1'b1;
          w_op_sub  = 1'b1;
          w_operand = w_upg_cost;
        end
      end
      ST_PROD: begin
        w_do_op   = 1'b1;
        w_operand = WW'(r_count[r_idx]) << r_idx;
      end
      default: ;
    endcase
  end

  // Subtraction only follows a passed compare, so the low bits hold the full cost.
  assign w_alu_res = w_op_sub ? (r_balance - w_operand[BAL_W-1:0])
                              : BAL_W'(sat_add(64'(r_balance), 64'(w_operand), BAL_W));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_balance    <= '0;
      for (int i = 0; i < NUM_BUILDINGS; i++) r_count[i] <= '0;
      r_sel_idx    <= 3'd0;
      r_buy_idx    <= 3'd0;
      r_idx        <= 3'd0;
      r_click_lvl  <= 3'd0;
      r_click_pend <= 1'b0;
      r_buy_pend   <= 1'b0;
      r_upg_pend   <= 1'b0;
      r_tick_pend  <= 1'b0;
      r_buy_ok     <= 1'b0;
      r_buy_fail   <= 1'b0;
    end else begin
      r_buy_ok     <= 1'b0;
      r_buy_fail   <= 1'b0;
      if (w_do_op) r_balance <= w_alu_res;
      if (selection && (|w_sel_vec)) r_sel_idx <= w_sel_new;
      r_click_pend <= (r_click_pend & ~w_clr_click) | click;
      r_buy_pend   <= (r_buy_pend & ~w_clr_buy) | buy;
      r_upg_pend   <= (r_upg_pend & ~w_clr_upg) | upgradeClick;
      r_tick_pend  <= (r_tick_pend & ~w_clr_tick) | w_tick;
      case (r_state)
        ST_IDLE: begin
          if (r_tick_pend) begin
            r_state <= ST_PROD;
            r_idx   <= 3'd0;
          end else if (r_buy_pend) begin
            r_state   <= ST_BUY_CHK;
            r_buy_idx <= r_sel_idx;
          end else if (r_upg_pend) begin
            r_state <= ST_UPG_CHK;
          end
        end
        ST_BUY_CHK: begin
          if (w_buy_pass) begin
            r_count[r_buy_idx] <= r_count[r_buy_idx] + 1'b1;
            r_buy_ok           <= 1'b1;
          end else begin
            r_buy_fail <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        ST_UPG_CHK: begin
          if (w_upg_pass) r_click_lvl <= r_click_lvl + 3'd1;
          r_state <= ST_IDLE;
        end
        ST_PROD: begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'(NUM_BUILDINGS - 1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef GAME_TOTAL_EARNED_EN
  logic [BAL_W-1:0] r_total_earned;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_total_earned <= '0;
    end else if (w_do_op && !w_op_sub) begin
      r_total_earned <= BAL_W'(sat_add(64'(r_total_earned), 64'(w_operand), BAL_W));
    end
  end

  assign total_earned = r_total_earned;
`endif

  assign balance   = r_balance;
  assign sel_idx   = r_sel_idx;
  assign sel_count = r_count[r_sel_idx];
  assign click_lvl = r_click_lvl;
  assign buy_ok    = r_buy_ok;
  assign buy_fail  = r_buy_fail;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/game_scheduler.md
Name: game_scheduler

Overview:
- Sequences the cookie game datapath from the one-cycle command pulses produced by the keyboard logic controller.
- Owns the cookie balance register, eight building counts, the click level and the production tick.
- Arbitrates a single shared saturating add/subtract unit between four requesters: click, buy, upgrade and production tick. The unit performs one operation per cycle.

Parameters:
- BAL_W, 32, balance width in bits.
- CNT_W, 8, per-building count width in bits.
- TICK_DIV, 50000000, clock cycles per production tick.
- PRICE_BASE, 10, price of building 0. Building i costs PRICE_BASE << (2*i).
- UPG_BASE, 50, cost of a click upgrade, equal to UPG_BASE << click_lvl.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- click  in  1  one-cycle pulse: add click power.
- buy  in  1  one-cycle pulse: buy the selected building.
- one..eight  in  1 each  one-cycle pulses that select building 0..7.
- selection  in  1  high alongside any of one..eight. Qualifies the selection.
- upgradeClick  in  1  one-cycle pulse: buy a click upgrade.
- balance  out  BAL_W  current cookies.
- sel_idx  out  3  currently selected building.
- sel_count  out  CNT_W  count of the selected building.
- click_lvl  out  3  click power is 1 << click_lvl.
- buy_ok  out  1  one-cycle pulse: purchase committed.
- buy_fail  out  1  one-cycle pulse: purchase rejected.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, resetn=0): all of the following are cleared immediately, including mid-operation.
  - balance=0, all counts=0, sel_idx=0, click_lvl=0.
  - buy_ok=0, buy_fail=0, busy=0.
  - All pending flags cleared, tick counter=0, state=IDLE.
- Selection:
  - When selection=1, sel_idx is loaded from the asserted one..eight at that edge. This takes effect at any time.
  - Several of one..eight high together: the lowest index wins.
  - A buy latches sel_idx on entry to BUY_CHK. Later selections do not affect an in-flight buy.
- Pending flags:
  - click, buy, upgradeClick and tick-wrap each set their own pending flag at the sampling edge.
  - Repeat pulses while a flag is already set merge into one request and are not counted.
  - If a flag is set and cleared on the same edge, set wins.
- Tick:
  - The counter runs 0..TICK_DIV-1 continuously, including while busy.
  - On wrap it sets tick_pend.
- FSM states: IDLE, BUY_CHK, UPG_CHK, PROD.
- IDLE priority: tick_pend, then buy_pend, then upg_pend, then click_pend.
  - Tick: go to PROD with idx=0. Clear tick_pend.
  - Buy: go to BUY_CHK. Clear buy_pend.
  - Upgrade: go to UPG_CHK. Clear upg_pend.
  - Click: balance += 1<<click_lvl, saturating, on this edge. Stay in IDLE and clear click_pend.
- Click latency: pulse sampled at edge E0, balance updated at E1 when nothing of higher priority is pending.
- BUY_CHK (1 cycle), price p = PRICE_BASE << (2*idx):
  - If balance >= p and count[idx] < 2^CNT_W-1: balance -= p, count[idx]++, buy_ok=1 for one cycle.
  - Otherwise: no state change and buy_fail=1 for one cycle.
  - Always returns to IDLE.
- UPG_CHK (1 cycle):
  - If click_lvl < 7 and balance >= UPG_BASE<<click_lvl: subtract the cost and increment click_lvl.
  - Otherwise: no change.
  - Returns to IDLE. No ok/fail pulses are generated.
- PROD (8 cycles, idx 0..7):
  - Each cycle: balance += count[idx] << idx, saturating.
  - After idx=7, return to IDLE.
- Arithmetic:
  - All additions saturate at 2^BAL_W-1.
  - Subtraction only occurs after a passed compare, so it never wraps.
  - Intermediate results are computed at BAL_W+CNT_W+7 bits, then clamped.
- A tick wrap during PROD sets tick_pend, which is serviced after the return to IDLE.

Optional Feature:
- Macro: GAME_TOTAL_EARNED_EN.
- Defined:
  - Adds output total_earned [BAL_W-1:0], reset to 0.
  - Incremented by every click and production addition, saturating.
  - Never decremented.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package game_pkg holds:
  - the state enum;
  - NUM_BUILDINGS=8 and MAX_CLICK_LVL=7;
  - a price function of (index, PRICE_BASE);
  - a saturating-add function.
- One sub-module, game_tick_divider:
  - parameter TICK_DIV;
  - outputs a one-cycle tick pulse;
  - uses the same clock and reset.

Test Plan (PRICE_BASE=10, UPG_BASE=50, TICK_DIV=64 unless noted):
- Reset, then 12 click pulses spaced 4 cycles apart -> balance=12. Each update lands 2 edges after its pulse.
- balance=12, select building 0 (one + selection), buy -> buy_ok pulse, balance=2, sel_count=1. A second buy -> buy_fail, balance unchanged at 2.
- balance=60, upgradeClick -> click_lvl=1, balance=10. A following click -> balance=12.
- count0=3, count2=1, tick fires -> after 8 PROD cycles balance increases by 3+4=7.
- click, buy and tick pend together -> PROD runs first, then BUY_CHK, then the click add. busy=1 throughout PROD.
- Saturation, with BAL_W=8 and balance=254: 4 clicks at click_lvl=1 -> balance=255 and no wrap.
- Reset mid-PROD, with resetn=0 at idx=3 -> all outputs return to 0 immediately, and the state is IDLE after release.
